// File: rtl/my_dmux_pkg.sv
// Shared types and constants for the 4-way demux scheduler.
package my_dmux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  typedef logic [1:0] chan_t;

  // Round-robin successor; natural 2-bit wrap gives 3 -> 0.
  function automatic chan_t chan_inc(chan_t c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/my_dmux_4_way.sv
// 1-to-4 demux of a single bit onto one-hot outputs.
module my_dmux_4_way
  import my_dmux_pkg::*;
(
  input  logic       in,
  input  chan_t      sel,
  output logic [3:0] out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign out[gi] = in && (sel == chan_t'(gi));
  end

endmodule

// File: rtl/my_dmux_4_way_sched.sv
// One-entry buffered scheduler steering a valid/ready stream to four consumers.
// Destination is latched at capture so out_valid never depends on out_ready.
module my_dmux_4_way_sched
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_mode,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic [4*CW-1:0]   del_count,
  output logic              busy
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      hold_data;
  chan_t                 dest_q;
  chan_t                 rr_ptr;
  logic [3:0][CW-1:0]    cnt_q;
  logic                  hold_valid;
  logic                  fire;
  logic                  capture;

  assign hold_valid = (state_q == S_FULL);
  assign fire       = hold_valid && out_ready[dest_q];
  assign capture    = in_valid && in_ready;

  // Next-state and handshake: accept when empty or when the held item leaves.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_FULL;
      end
      S_FULL: begin
        in_ready = fire;
        if (fire && !in_valid) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Capture payload and destination; pointer moves only on round-robin captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      dest_q    <= '0;
      rr_ptr    <= '0;
    end else if (capture) begin
      hold_data <= in_data;
      if (cfg_mode == MODE_RR) begin
        dest_q <= rr_ptr;
        rr_ptr <= chan_inc(rr_ptr);
      end else begin
        dest_q <= in_dest;
      end
    end
  end

  // Per-channel delivery counters, wrapping modulo 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (fire) begin
      for (int n = 0; n < 4; n++)
        if (dest_q == chan_t'(n)) cnt_q[n] <= cnt_q[n] + CW'(1);
    end
  end

  my_dmux_4_way u_dmux (
    .in  (hold_valid),
    .sel (dest_q),
    .out (out_valid)
  );

  assign out_data  = hold_data;
  assign sel       = dest_q;
  assign del_count = cnt_q;
  assign busy      = hold_valid;

endmodule

// File: doc/my_dmux_4_way_sched.md
# my_dmux_4_way_sched

Scheduler that sequences a shared `my_dmux_4_way` datapath, steering a single valid/ready input stream to one of four valid/ready consumers. It holds one item in a one-entry buffer. The destination is taken from an address field or from a round-robin pointer. It drives the demux select and keeps a per-channel delivery count. It sits between a single producer and four consumer channels.

## Interface
- `WIDTH`, default 8: data width of the item.
- `CW`, default 8: width of each per-channel delivery counter.

- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_mode`  in  1: 0 = addressed (use `in_dest`), 1 = round-robin. Sampled only at capture.
- `in_data`  in  WIDTH: item payload.
- `in_dest`  in  2: destination channel in addressed mode; ignored in round-robin mode.
- `in_valid`  in  1: producer has an item.
- `in_ready`  out  1: scheduler accepts an item this cycle.
- `out_data`  out  WIDTH: held payload, a shared bus to all four consumers.
- `out_valid`  out  4: one-hot per-channel valid; bit n means channel n.
- `out_ready`  in  4: per-channel consumer ready.
- `sel`  out  2: demux select; 0..3 maps to a..d.
- `del_count`  out  4*CW: delivery counters; channel n occupies bits [n*CW +: CW].
- `busy`  out  1: a held item is awaiting delivery.

## Operation
- The block has two states: EMPTY (`hold_valid`=0) and FULL (`hold_valid`=1).
- `in_ready` = !hold_valid || fire, where fire = hold_valid && out_ready[sel]. It is combinational and allows full throughput.
- **Capture** occurs when in_valid && in_ready:
  - `hold_data` ← in_data.
  - The destination is registered: in addressed mode, dest ← in_dest; in round-robin mode, dest ← rr_ptr and rr_ptr ← rr_ptr+1 mod 4 (3→0).
  - State becomes FULL.
- **Destination rule:** the destination is fixed at capture. `out_valid` never depends on `out_ready` (no combinational valid-from-ready path).
- **Delivery** outputs:
  - sel = registered dest.
  - out_valid = dmux(hold_valid, sel): exactly one bit is set when FULL, and all bits are 0 when EMPTY.
  - out_data = hold_data.
- **On fire:**
  - del_count[sel] increments, wrapping modulo 2^CW.
  - If a capture occurs in the same cycle, state stays FULL with the new item and destination. Otherwise the state goes to EMPTY.
- **Ready on other channels:** out_ready on non-selected channels is ignored. A non-ready destination stalls the stream indefinitely. There is no skipping and no timeout.
- **Pointer advance:** rr_ptr advances only on round-robin-mode captures. Addressed-mode captures leave rr_ptr unchanged.
- **Mode change:** a change in cfg_mode affects only the next capture. A held item keeps its destination.
- **busy** = hold_valid.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert handled externally) sets:
  - hold_valid=0, out_valid=4'b0000, sel=0, rr_ptr=0, out_data=0, all del_count=0, busy=0.
  - in_ready=1.
- Reset mid-operation discards the held item, and counters and rr_ptr return to 0.
- Latency: an item captured at edge k appears on out_valid/out_data/sel after edge k, and is deliverable in cycle k+1.
- Delivery fires at the first edge where out_ready[sel]=1.
- Steady-state throughput: one item per cycle when the destination consumer is always ready.
- sel and out_data are stable throughout a stall. out_valid is held high until fire.
- Counter update is visible the cycle after fire.
- Counter wrap: (2^CW)-1 → 0 with no saturation flag.

## Structure
- Shared package `my_dmux_pkg` contains:
  - MODE_ADDR=1'b0, MODE_RR=1'b1.
  - State enum {S_EMPTY, S_FULL}.
  - A channel index typedef (2 bits).
- Sub-module: one `my_dmux_4_way` instance generates out_valid[3:0] from in=hold_valid and sel. The scheduler does not re-decode sel itself.
- The counter bank is inline in this block as four CW-bit registers.

## Test plan
- Reset then idle: out_valid=0000, in_ready=1, del_count all 0, sel=0.
- Addressed mode:
  - Stimulus: dests 2,0,3,1 with data 8'hA0..A3, all out_ready=1111.
  - Required response: out_valid is 0100, 0001, 1000, 0010 on consecutive cycles with matching data. Each del_count=1.
- Round-robin mode:
  - Stimulus: 6 back-to-back items with out_ready=1111.
  - Required response: sel sequence 0,1,2,3,0,1. Counts are 2,2,1,1, and rr_ptr ends at 2.
- Stall:
  - Stimulus: destination 1 with out_ready[1]=0 for 5 cycles while other ready bits are 1.
  - Required response: out_valid=0010, and in_ready=0 while full. Data is held. Release gives exactly one fire, and count[1] increments once.
- Simultaneous fire and capture: after release, a new item to destination 3 is captured on the same edge. The next cycle shows out_valid=1000 with no empty bubble.
- Wrap and reset:
  - Deliver 256 items to channel 0 with CW=8. Required response: count[0]=0.
  - Assert rst_n=0 while FULL. Required response: out_valid immediately becomes 0000 and busy=0.
